// File: rtl/regfile_onehot_8x16.sv
// 8-entry register file addressed by a one-hot write select, with write-bypassed
// combinational reads, a pending-producer scoreboard and malformed-select detection.
module regfile_onehot_8x16 #(
  parameter int DATA_WIDTH = 16,
  parameter bit ZERO_R0    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [2:0]            rd_addr_a,
  input  logic [2:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  mark_en,
  input  logic [7:0]            mark_sel,
  output logic                  pend_a,
  output logic                  pend_b,
  output logic [7:0]            pending,
  output logic                  sel_err
);

  logic [DATA_WIDTH-1:0] regs_q [8];
  logic [DATA_WIDTH-1:0] regs_d [8];
  logic [7:0]            pending_q, pending_d;
  logic                  sel_err_q, sel_err_d;

  logic       wr_multi, mk_multi;
  logic [7:0] wr_hit, mk_hit, r0_mask;

  assign r0_mask = ZERO_R0 ? 8'hFE : 8'hFF;

  always_comb begin
    // x & (x-1) is non-zero exactly when two or more bits are set
    wr_multi  = (wr_sel & (wr_sel - 8'd1)) != '0;
    mk_multi  = (mark_sel & (mark_sel - 8'd1)) != '0;
    wr_hit    = (wr_en && !wr_multi) ? (wr_sel & r0_mask) : '0;
    mk_hit    = (mark_en && !mk_multi) ? (mark_sel & r0_mask) : '0;
    // mark applied after the writeback clear so a new producer wins
    pending_d = (pending_q & ~wr_hit) | mk_hit;
    sel_err_d = (wr_en && wr_multi) || (mark_en && mk_multi);
    for (int unsigned i = 0; i < 8; i++) begin
      regs_d[i] = wr_hit[i] ? wr_data : regs_q[i];
    end
  end

  always_comb begin
    rd_data_a = wr_hit[rd_addr_a] ? wr_data : regs_q[rd_addr_a];
    rd_data_b = wr_hit[rd_addr_b] ? wr_data : regs_q[rd_addr_b];
    if (ZERO_R0 && rd_addr_a == 3'd0) rd_data_a = '0;
    if (ZERO_R0 && rd_addr_b == 3'd0) rd_data_b = '0;
    pend_a = pending_d[rd_addr_a];
    pend_b = pending_d[rd_addr_b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= '0;
      pending_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      pending_q <= pending_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign pending = pending_q;
  assign sel_err = sel_err_q;

endmodule
